// File: rtl/if_prefetch_stage_if.sv
// Bundle of the fetch-stage signals: ROM port, redirect/halt control and the decode handshake.
// The master modport is the fetch stage, the slave modport is its surroundings.
interface if_prefetch_stage_if #(
   parameter int ADDR_W     = 8,
   parameter int BYTE_W     = 8,
   parameter int OPC_W      = 3,
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [ADDR_W-1:0]       rom_addr;
   logic [BYTE_W-1:0]       rom_data;
   logic                    redirect_valid;
   logic [ADDR_W-1:0]       redirect_pc;
   logic                    halt;
   logic                    out_valid;
   logic                    out_ready;
   logic [OPC_W-1:0]        out_opcode;
   logic [BYTE_W-OPC_W-1:0] out_ad1;
   logic [BYTE_W-1:0]       out_imm;
   logic [ADDR_W-1:0]       out_pc;
   logic [CNT_W-1:0]        fifo_count;

   modport master (
      output rom_addr, input rom_data,
      input redirect_valid, input redirect_pc, input halt,
      output out_valid, input out_ready,
      output out_opcode, output out_ad1, output out_imm, output out_pc,
      output fifo_count
   );

   modport slave (
      input rom_addr, output rom_data,
      output redirect_valid, output redirect_pc, output halt,
      input out_valid, output out_ready,
      input out_opcode, input out_ad1, input out_imm, input out_pc,
      input fifo_count
   );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: ROM bytes are prefetched one per cycle into a small FIFO and
// 1- or 2-byte instructions are assembled from its head for the decode stage.
module if_prefetch_stage #(
   parameter int                  ADDR_W        = 8,
   parameter int                  BYTE_W        = 8,
   parameter int                  OPC_W         = 3,
   parameter int                  FIFO_DEPTH    = 4,
   parameter logic [ADDR_W-1:0]   RESET_PC      = '0,
   parameter logic [2**OPC_W-1:0] TWO_BYTE_MASK = 8'b0000_1110
) (
   input  logic                 clk,
   input  logic                 rst,
   if_prefetch_stage_if.master  bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int AD1_W = BYTE_W - OPC_W;

   typedef logic [BYTE_W-1:0] byte_t;

   byte_t              fifo_q [FIFO_DEPTH];
   byte_t              fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [ADDR_W-1:0]  pc_q, pc_d, head_pc_q, head_pc_d;
   logic               out_valid_q, out_valid_d;
   logic [OPC_W-1:0]   out_opcode_q, out_opcode_d;
   logic [AD1_W-1:0]   out_ad1_q, out_ad1_d;
   logic [BYTE_W-1:0]  out_imm_q, out_imm_d;
   logic [ADDR_W-1:0]  out_pc_q, out_pc_d;

   byte_t              head_byte, next_byte;
   logic [OPC_W-1:0]   head_opc;
   logic               need_two, slot_free, push;
   logic [CNT_W-1:0]   need_n, pop_n;

   // Pointers wrap explicitly so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Decode handshake: an instruction transfers on a rising edge where out_valid && out_ready;
   // while out_valid && !out_ready the whole payload is held stable.
   always_comb begin
      fifo_d       = fifo_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      pc_d         = pc_q;
      head_pc_d    = head_pc_q;
      out_valid_d  = out_valid_q;
      out_opcode_d = out_opcode_q;
      out_ad1_d    = out_ad1_q;
      out_imm_d    = out_imm_q;
      out_pc_d     = out_pc_q;
      pop_n        = '0;
      push         = 1'b0;

      head_byte = fifo_q[rd_ptr_q];
      next_byte = fifo_q[ptr_inc(rd_ptr_q)];
      head_opc  = head_byte[BYTE_W-1 -: OPC_W];
      need_two  = TWO_BYTE_MASK[head_opc];
      need_n    = need_two ? CNT_W'(2) : CNT_W'(1);
      slot_free = !out_valid_q || bus.out_ready;

      if (bus.redirect_valid) begin
         pc_d        = bus.redirect_pc;
         head_pc_d   = bus.redirect_pc;
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
      end else if (bus.halt) begin
         if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
      end else begin
         if (slot_free) begin
            if (count_q >= need_n) begin
               out_valid_d  = 1'b1;
               out_opcode_d = head_opc;
               out_ad1_d    = head_byte[AD1_W-1:0];
               out_imm_d    = need_two ? next_byte : '0;
               out_pc_d     = head_pc_q;
               pop_n        = need_n;
               head_pc_d    = head_pc_q + ADDR_W'(need_n);
               rd_ptr_d     = need_two ? ptr_inc(ptr_inc(rd_ptr_q)) : ptr_inc(rd_ptr_q);
            end else begin
               out_valid_d = 1'b0;
            end
         end
         // Space freed by this cycle's pop is reusable in the same cycle.
         push = (count_q - pop_n) < CNT_W'(FIFO_DEPTH);
         if (push) begin
            fifo_d[wr_ptr_q] = bus.rom_data;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
            pc_d             = pc_q + 1'b1;
         end
         count_d = count_q - pop_n + CNT_W'(push);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         pc_q         <= RESET_PC;
         head_pc_q    <= RESET_PC;
         out_valid_q  <= 1'b0;
         out_opcode_q <= '0;
         out_ad1_q    <= '0;
         out_imm_q    <= '0;
         out_pc_q     <= '0;
      end else begin
         fifo_q       <= fifo_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         pc_q         <= pc_d;
         head_pc_q    <= head_pc_d;
         out_valid_q  <= out_valid_d;
         out_opcode_q <= out_opcode_d;
         out_ad1_q    <= out_ad1_d;
         out_imm_q    <= out_imm_d;
         out_pc_q     <= out_pc_d;
      end
   end

   assign bus.rom_addr   = pc_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_opcode = out_opcode_q;
   assign bus.out_ad1    = out_ad1_q;
   assign bus.out_imm    = out_imm_q;
   assign bus.out_pc     = out_pc_q;
   assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: start-up latency, backpressure, redirect, halt,
// address wrap and asynchronous reset, against a combinational ROM model.
module tb_if_prefetch_stage;
   localparam int ADDR_W     = 8;
   localparam int BYTE_W     = 8;
   localparam int OPC_W      = 3;
   localparam int FIFO_DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  rom [256];

   if_prefetch_stage_if #(.ADDR_W(ADDR_W), .BYTE_W(BYTE_W), .OPC_W(OPC_W),
                          .FIFO_DEPTH(FIFO_DEPTH)) bus ();

   if_prefetch_stage #(.ADDR_W(ADDR_W), .BYTE_W(BYTE_W), .OPC_W(OPC_W),
                       .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(8'h00),
                       .TWO_BYTE_MASK(8'b0000_1110)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.rom_data = rom[bus.rom_addr];

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic [2:0] op, input logic [4:0] ad1,
                                        input logic [7:0] imm, input logic [7:0] pc);
      return {8'h00, pc, imm, op, ad1};
   endfunction

   function automatic logic [31:0] obs();
      return {8'h00, bus.out_pc, bus.out_imm, bus.out_opcode, bus.out_ad1};
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 8'h00;
      bus.halt           = 1'b0;
      bus.out_ready      = 1'b1;
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic redirect(input logic [7:0] target);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      tick();
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = {3'b111, 5'(i)};
      rom[0] = 8'hE1; rom[1] = 8'h25; rom[2] = 8'hAA; rom[3] = 8'hC2;

      // reset values and start-up latency
      do_reset();
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_count", 32'(bus.fifo_count), 32'd0);
      chk("rst_addr", 32'(bus.rom_addr), 32'h00);
      chk("rst_payload", obs(), 32'h0);
      tick();
      chk("e1_valid", 32'(bus.out_valid), 32'd0);
      chk("e1_count", 32'(bus.fifo_count), 32'd1);
      tick();
      chk("e2_valid", 32'(bus.out_valid), 32'd1);
      chk("e2_instr", obs(), pack(3'd7, 5'd1, 8'h00, 8'h00));
      tick();
      chk("e3_bubble", 32'(bus.out_valid), 32'd0);
      tick();
      chk("e4_instr", obs(), pack(3'd1, 5'd5, 8'hAA, 8'h01));
      tick();
      chk("e5_instr", obs(), pack(3'd6, 5'd2, 8'h00, 8'h03));

      // backpressure: FIFO fills, PC freezes, output held
      do_reset();
      tick();
      tick();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_hold", {31'd0, bus.out_valid} ^ obs(), 32'd1 ^ pack(3'd7, 5'd1, 8'h00, 8'h00));
      end
      chk("stall_count", 32'(bus.fifo_count), 32'd4);
      chk("stall_addr", 32'(bus.rom_addr), 32'h05);
      exp_q.push_back(pack(3'd1, 5'd5, 8'hAA, 8'h01));
      exp_q.push_back(pack(3'd6, 5'd2, 8'h00, 8'h03));
      exp_q.push_back(pack(3'd7, 5'd4, 8'h00, 8'h04));
      exp_q.push_back(pack(3'd7, 5'd5, 8'h00, 8'h05));
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         tick();
         if (bus.out_valid) chk("order", obs(), exp_q.pop_front());
      end
      chk("drain", 32'(exp_q.size()), 32'd0);

      // redirect while a 2-byte instruction is half fetched
      rom[8'h10] = 8'h25; rom[8'h11] = 8'h77;
      redirect(8'h10);
      tick();
      chk("half_count", 32'(bus.fifo_count), 32'd1);
      chk("half_addr", 32'(bus.rom_addr), 32'h11);
      redirect(8'h40);
      chk("redir_valid", 32'(bus.out_valid), 32'd0);
      chk("redir_count", 32'(bus.fifo_count), 32'd0);
      chk("redir_addr", 32'(bus.rom_addr), 32'h40);
      tick();
      chk("redir_nostale", 32'(bus.out_valid), 32'd0);
      tick();
      chk("redir_instr", obs(), pack(3'd7, 5'd0, 8'h00, 8'h40));
      chk("redir_valid2", 32'(bus.out_valid), 32'd1);
      chk("redir_addr2", 32'(bus.rom_addr), 32'h42);

      // halt: hold while stalled, drop valid on accept, resume at frozen PC
      bus.halt = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      chk("halt_hold", obs(), pack(3'd7, 5'd0, 8'h00, 8'h40));
      chk("halt_hvalid", 32'(bus.out_valid), 32'd1);
      chk("halt_addr", 32'(bus.rom_addr), 32'h42);
      bus.out_ready = 1'b1;
      tick();
      chk("halt_drop", 32'(bus.out_valid), 32'd0);
      chk("halt_addr2", 32'(bus.rom_addr), 32'h42);
      chk("halt_count", 32'(bus.fifo_count), 32'd1);
      bus.halt = 1'b0;
      tick();
      chk("resume_instr", obs(), pack(3'd7, 5'd1, 8'h00, 8'h41));
      chk("resume_addr", 32'(bus.rom_addr), 32'h43);

      // 2-byte instruction across the address wrap
      rom[8'hFF] = 8'h45; rom[8'h00] = 8'h9C;
      redirect(8'hFF);
      chk("wrap_addr0", 32'(bus.rom_addr), 32'hFF);
      tick();
      chk("wrap_addr1", 32'(bus.rom_addr), 32'h00);
      tick();
      chk("wrap_addr2", 32'(bus.rom_addr), 32'h01);
      chk("wrap_wait", 32'(bus.out_valid), 32'd0);
      tick();
      chk("wrap_instr", obs(), pack(3'd2, 5'd5, 8'h9C, 8'hFF));
      chk("wrap_addr3", 32'(bus.rom_addr), 32'h02);

      // asynchronous reset pulse mid-burst
      rom[8'h00] = 8'hE1;
      tick();
      tick();
      #3;
      rst = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_count", 32'(bus.fifo_count), 32'd0);
      chk("arst_addr", 32'(bus.rom_addr), 32'h00);
      chk("arst_pc", 32'(bus.out_pc), 32'h00);
      rst = 1'b1;
      tick();
      chk("arst_e1_count", 32'(bus.fifo_count), 32'd1);
      chk("arst_e1_addr", 32'(bus.rom_addr), 32'h01);
      tick();
      chk("arst_e2_instr", obs(), pack(3'd7, 5'd1, 8'h00, 8'h00));
      chk("arst_e2_valid", 32'(bus.out_valid), 32'd1);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
Parametrised instruction-fetch stage with a byte prefetch FIFO. It decouples ROM reads from decode: ROM bytes are fetched one per cycle into the FIFO, and 1- or 2-byte instructions are assembled from the FIFO head. Assembled instructions are presented to decode over a valid/ready handshake. Supports branch redirect with flush, halt, and configurable widths and opcode-length decoding. It sits between the program ROM and the ID stage.

Parameters:
ADDR_W, 8, PC and ROM address width.
BYTE_W, 8, ROM word / instruction byte width; opcode is the top OPC_W bits, operand field is the rest.
OPC_W, 3, opcode field width.
FIFO_DEPTH, 4, prefetch FIFO entries (bytes), >=2.
RESET_PC, 0, PC value after reset.
TWO_BYTE_MASK, 8'b0000_1110, 2**OPC_W bits; bit k=1 means opcode k is a 2-byte instruction (default: 001, 010, 011).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
rom_addr  out  ADDR_W  ROM read address (= PC, combinational from PC register).
rom_data  in  BYTE_W  ROM data for rom_addr, same-cycle combinational.
redirect_valid  in  1  load new PC and flush.
redirect_pc  in  ADDR_W  redirect target.
halt  in  1  freeze fetch and issue.
out_valid  out  1  instruction held on outputs.
out_ready  in  1  decode accepts (replaces stall; stall = !out_ready).
out_opcode  out  OPC_W  opcode.
out_ad1  out  BYTE_W-OPC_W  operand field.
out_imm  out  BYTE_W  second byte; 0 for 1-byte instructions.
out_pc  out  ADDR_W  address of the instruction's first byte.
fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst=0, async):
  - PC=RESET_PC, head_pc=RESET_PC.
  - FIFO empty (fifo_count=0).
  - out_valid=0; out_opcode, out_ad1, out_imm and out_pc are all 0.
- Priority each edge: redirect > halt > normal.
- Redirect:
  - PC<=redirect_pc and head_pc<=redirect_pc.
  - FIFO flushed, out_valid<=0 regardless of out_ready; the current rom_data is discarded.
- Halt (no redirect):
  - No push, PC held, no new issue.
  - If out_valid&&out_ready, out_valid<=0; otherwise the output is held unchanged.
- Issue rule (normal mode):
  - out slot is free when !out_valid || out_ready.
  - Head opcode h=fifo[head][BYTE_W-1 -: OPC_W]; need = TWO_BYTE_MASK[h] ? 2 : 1.
  - If the slot is free and fifo_count>=need:
    - load opcode, ad1 and out_pc=head_pc;
    - out_imm = the next entry if need=2, else 0;
    - pop need entries, head_pc += need (mod 2**ADDR_W), out_valid<=1.
  - If the slot is free and fifo_count<need, out_valid<=0.
  - If the slot is not free, all outputs are held stable. This is an AXI-style rule: the payload must not change while valid&&!ready.
- Push rule (normal mode):
  - push when (fifo_count - pop_n) < FIFO_DEPTH, with pop_n being this cycle's pop count.
  - On push, rom_data is written at tail and PC<=PC+1 (wraps 2**ADDR_W-1 -> 0). On no push, PC is held.
  - Push and pop in the same cycle are legal; fifo_count <= fifo_count + push - pop_n.
- No bypass path: a byte must be in the FIFO one edge before it can issue.
- Latency from reset release with out_ready=1:
  - a 1-byte instruction issues at edge 2;
  - a 2-byte instruction issues at edge 3;
  - steady state is 1 byte/cycle fetch bandwidth.
- A 2-byte instruction spanning the address wrap (first byte at 0xFF, imm at 0x00) assembles normally; out_pc=0xFF.
- Full FIFO with out_ready=0: PC frozen, no ROM byte lost, outputs stable.
- Redirect during a partially fetched 2-byte instruction drops the pending byte; no stale instruction issues afterwards.
- Reset asserted mid-operation returns everything to reset values immediately (async); the first fetch is from RESET_PC.
- Internal pointers are $clog2(FIFO_DEPTH) wide with an explicit count. Non-power-of-2 depth is supported by wrapping the pointers at FIFO_DEPTH-1.

Test Plan:
- ROM[0..3]=E1,25,AA,C2 (111/00001, 001/00101+imm AA, 110/00010), out_ready=1 -> edge 2: op=7 ad1=1 imm=0 pc=0; then op=1 ad1=5 imm=AA pc=1; then op=6 ad1=2 pc=3.
- out_ready=0 for 10 cycles after the first valid -> fifo_count saturates at 4, rom_addr stops at first_pc+5, outputs unchanged; release -> next instructions issue in order, none skipped or duplicated.
- redirect_valid=1, redirect_pc=0x40 while the 2-byte instruction at 0x10 is half fetched -> out_valid=0 next edge, fifo_count=0; the next issued out_pc=0x40.
- halt=1 with out_valid=1 and out_ready=0 -> output held; set out_ready=1 -> out_valid drops, PC frozen; halt=0 -> fetch resumes at the frozen PC.
- redirect_pc=0xFF with ROM[FF]=45 and ROM[00]=9C -> op=2 ad1=5 imm=9C out_pc=FF; rom_addr then continues at 01.
- rst pulsed low mid-burst for 1 ns, asynchronous to clk -> out_valid=0 and fifo_count=0 immediately; fetch restarts at RESET_PC.
